// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the RV32I multi-cycle controller: decoder flags,
// memory handshakes, datapath enables/selects and status.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             r;
    logic             load;
    logic             store;
    logic             branch;
    logic             itype;
    logic             jalr;
    logic             jal;
    logic             lui;
    logic             br_taken;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             ir_en;
    logic             dmem_req;
    logic             dmem_we;
    logic [1:0]       alu_a_sel;
    logic             alu_b_sel;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             pc_en;
    logic [1:0]       pc_sel;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             trap;
    logic [1:0]       trap_cause;

    modport master (
        input  r, load, store, branch, itype, jalr, jal, lui,
        input  br_taken, imem_ack, dmem_ack,
        output imem_req, ir_en, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
        output rf_we, wb_sel, pc_en, pc_sel, retire, instret, trap, trap_cause
    );

    modport slave (
        output r, load, store, branch, itype, jalr, jal, lui,
        output br_taken, imem_ack, dmem_ack,
        input  imem_req, ir_en, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
        input  rf_we, wb_sel, pc_en, pc_sel, retire, instret, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory-timeout and illegal-class traps and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic [CNT_W-1:0]  instret;
    logic [1:0]        trap_cause;
    logic [1:0]        cause_nxt;
    logic [7:0]        flags;
    logic              timeout;
    logic [1:0]        a_sel;
    logic              b_sel;

    assign flags   = {bus.r, bus.load, bus.store, bus.branch,
                      bus.itype, bus.jalr, bus.jal, bus.lui};
    assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // ALU operand selects by instruction class (shared by EXEC and MEM)
    always_comb begin
        a_sel = 2'b00;
        b_sel = 1'b1;
        if (bus.r || bus.branch) b_sel = 1'b0;
        if (bus.lui)      a_sel = 2'b10;
        else if (bus.jal) a_sel = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            instret    <= '0;
            trap_cause <= 2'b00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (bus.retire) instret <= instret + CNT_W'(1);
            if (state != TRAP && state_nxt == TRAP) trap_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = '0;
        cause_nxt      = 2'b00;
        bus.imem_req   = 1'b0;
        bus.ir_en      = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.alu_a_sel  = 2'b00;
        bus.alu_b_sel  = 1'b0;
        bus.rf_we      = 1'b0;
        bus.wb_sel     = 2'b00;
        bus.pc_en      = 1'b0;
        bus.pc_sel     = 2'b00;
        bus.retire     = 1'b0;
        bus.trap       = 1'b0;
        bus.trap_cause = trap_cause;
        bus.instret    = instret;

        unique case (state)
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    bus.ir_en = 1'b1;
                    state_nxt = DECODE;
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b01;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            DECODE: begin
                if (!$onehot(flags)) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b10;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                bus.alu_a_sel = a_sel;
                bus.alu_b_sel = b_sel;
                if (bus.branch) begin
                    bus.pc_en  = 1'b1;
                    bus.pc_sel = bus.br_taken ? 2'b01 : 2'b00;
                    bus.retire = 1'b1;
                    state_nxt  = FETCH;
                end else if (bus.load || bus.store) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                bus.dmem_req  = 1'b1;
                bus.dmem_we   = bus.store;
                bus.alu_a_sel = a_sel;
                bus.alu_b_sel = b_sel;
                if (bus.dmem_ack) begin
                    if (bus.store) begin
                        bus.pc_en  = 1'b1;
                        bus.retire = 1'b1;
                        state_nxt  = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b01;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            WB: begin
                bus.rf_we  = 1'b1;
                bus.pc_en  = 1'b1;
                bus.retire = 1'b1;
                if (bus.load)                bus.wb_sel = 2'b01;
                else if (bus.jal || bus.jalr) bus.wb_sel = 2'b10;
                if (bus.jal)       bus.pc_sel = 2'b10;
                else if (bus.jalr) bus.pc_sel = 2'b11;
                state_nxt = FETCH;
            end
            TRAP: begin
                bus.trap = 1'b1;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        // Reset silences every output so an abandoned instruction has no effect
        if (rst) begin
            bus.imem_req   = 1'b0;
            bus.ir_en      = 1'b0;
            bus.dmem_req   = 1'b0;
            bus.dmem_we    = 1'b0;
            bus.alu_a_sel  = 2'b00;
            bus.alu_b_sel  = 1'b0;
            bus.rf_we      = 1'b0;
            bus.wb_sel     = 2'b00;
            bus.pc_en      = 1'b0;
            bus.pc_sel     = 2'b00;
            bus.retire     = 1'b0;
            bus.trap       = 1'b0;
            bus.trap_cause = 2'b00;
            bus.instret    = '0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors with hand-computed
// expectations, traps, reset abandonment and a 4-bit instret wrap.
module tb_multicycle_ctrl;
    localparam int unsigned CNT_W = 4;

    localparam logic [7:0] C_R     = 8'h80;
    localparam logic [7:0] C_LOAD  = 8'h40;
    localparam logic [7:0] C_STORE = 8'h20;
    localparam logic [7:0] C_BR    = 8'h10;
    localparam logic [7:0] C_I     = 8'h08;
    localparam logic [7:0] C_JALR  = 8'h04;
    localparam logic [7:0] C_JAL   = 8'h02;
    localparam logic [7:0] C_LUI   = 8'h01;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [16:0] f_ack;
    logic [16:0] f_wait;
    logic [16:0] idle;
    logic [16:0] wb_plain;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // {imem_req, ir_en, dmem_req, dmem_we, a_sel, b_sel, rf_we, wb_sel, pc_en, pc_sel, retire, trap, cause}
    function automatic logic [16:0] mk(logic ireq, logic ir, logic dreq, logic dwe, logic [1:0] a,
                                       logic b, logic rfwe, logic [1:0] wb, logic pce,
                                       logic [1:0] pcs, logic ret, logic tr, logic [1:0] cause);
        return {ireq, ir, dreq, dwe, a, b, rfwe, wb, pce, pcs, ret, tr, cause};
    endfunction

    function automatic logic [16:0] outs();
        return {bus.imem_req, bus.ir_en, bus.dmem_req, bus.dmem_we, bus.alu_a_sel,
                bus.alu_b_sel, bus.rf_we, bus.wb_sel, bus.pc_en, bus.pc_sel,
                bus.retire, bus.trap, bus.trap_cause};
    endfunction

    task automatic set_cls(input logic [7:0] f);
        {bus.r, bus.load, bus.store, bus.branch, bus.itype, bus.jalr, bus.jal, bus.lui} = f;
    endtask

    // Drive inputs for one cycle, check outputs mid-cycle, then advance past the edge
    task automatic step(input string tag, input logic ia, input logic da, input logic bt,
                        input logic [16:0] exp);
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        bus.br_taken = bt;
        #1;
        check(tag, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("rst_outs", 1'b1, 1'b1, 1'b1, idle);
        step("rst_outs2", 1'b1, 1'b1, 1'b0, idle);
        rst = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [7:0] cls,
                           input logic [16:0] exp_exec, input logic [16:0] exp_wb);
        set_cls(cls);
        step({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, f_ack);
        step({tag, "_decode"}, 1'b1, 1'b1, 1'b0, idle);
        step({tag, "_exec"}, 1'b0, 1'b1, 1'b0, exp_exec);
        step({tag, "_wb"}, 1'b0, 1'b0, 1'b0, exp_wb);
    endtask

    task automatic run_branch(input string tag, input logic taken);
        set_cls(C_BR);
        step({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, f_ack);
        step({tag, "_decode"}, 1'b0, 1'b0, 1'b0, idle);
        step({tag, "_exec"}, 1'b0, 1'b0, taken,
             mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, taken ? 2'b01 : 2'b00, 1, 0, 2'b00));
    endtask

    initial begin
        f_ack    = mk(1, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00);
        f_wait   = mk(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00);
        idle     = '0;
        wb_plain = mk(0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 1, 2'b00, 1, 0, 2'b00);
        rst = 1'b1;
        set_cls(C_R);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_instret", 32'(bus.instret), 32'd0);

        // Reset while a load waits in MEM: abandoned, nothing retires
        set_cls(C_LOAD);
        step("ab_fetch", 1'b1, 1'b0, 1'b0, f_ack);
        step("ab_decode", 1'b0, 1'b0, 1'b0, idle);
        step("ab_exec", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00));
        step("ab_mem", 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00));
        rst = 1'b1;
        step("ab_rst", 1'b0, 1'b1, 1'b0, idle);
        rst = 1'b0;
        step("ab_refetch", 1'b0, 1'b0, 1'b0, f_wait);
        check("ab_instret", 32'(bus.instret), 32'd0);

        run_alu("r", C_R, idle, wb_plain);
        check("r_instret", 32'(bus.instret), 32'd1);

        // Load with dmem_ack two cycles late
        set_cls(C_LOAD);
        step("ld_fetch", 1'b1, 1'b0, 1'b0, f_ack);
        step("ld_decode", 1'b0, 1'b1, 1'b0, idle);
        step("ld_exec", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00));
        for (int i = 0; i < 3; i++)
            step("ld_mem", 1'b0, (i == 2), 1'b0, mk(0, 0, 1, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00));
        step("ld_wb", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 0, 1, 2'b01, 1, 2'b00, 1, 0, 2'b00));
        check("ld_instret", 32'(bus.instret), 32'd2);

        run_branch("bt", 1'b1);
        run_branch("bn", 1'b0);
        check("br_instret", 32'(bus.instret), 32'd4);

        run_alu("jalr", C_JALR, mk(0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00),
                mk(0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 1, 2'b11, 1, 0, 2'b00));
        run_alu("jal", C_JAL, mk(0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00),
                mk(0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 1, 2'b10, 1, 0, 2'b00));
        run_alu("lui", C_LUI, mk(0, 0, 0, 0, 2'b10, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00), wb_plain);
        run_alu("itype", C_I, mk(0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00), wb_plain);

        set_cls(C_STORE);
        step("st_fetch", 1'b1, 1'b0, 1'b0, f_ack);
        step("st_decode", 1'b0, 1'b0, 1'b0, idle);
        step("st_exec", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00));
        step("st_mem", 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 2'b00, 1, 0, 2'b00, 1, 2'b00, 1, 0, 2'b00));
        check("st_instret", 32'(bus.instret), 32'd9);

        // Seven more retires take the 4-bit counter from 9 through 15 to 0
        for (int i = 0; i < 7; i++) run_branch("wrap", 1'b0);
        check("wrap_zero", 32'(bus.instret), 32'd0);
        run_branch("wrap1", 1'b1);
        check("wrap_one", 32'(bus.instret), 32'd1);

        // Two class flags at once -> illegal-class trap
        set_cls(C_R | C_I);
        step("ill_fetch", 1'b1, 1'b0, 1'b0, f_ack);
        step("ill_decode", 1'b0, 1'b0, 1'b0, idle);
        step("ill_trap", 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10));
        step("ill_hold", 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10));
        check("ill_instret", 32'(bus.instret), 32'd1);

        // Ack arriving exactly on the timeout cycle wins
        set_cls(C_R);
        do_reset();
        check("rst2_instret", 32'(bus.instret), 32'd0);
        for (int i = 0; i < 15; i++) step("aw_wait", 1'b0, 1'b1, 1'b0, f_wait);
        step("aw_ack", 1'b1, 1'b0, 1'b0, f_ack);
        step("aw_decode", 1'b0, 1'b0, 1'b0, idle);
        step("aw_exec", 1'b0, 1'b0, 1'b0, idle);
        step("aw_wb", 1'b0, 1'b0, 1'b0, wb_plain);
        check("aw_instret", 32'(bus.instret), 32'd1);

        // imem never acks: 16 FETCH cycles then memory-timeout trap
        for (int i = 0; i < 16; i++) step("to_wait", 1'b0, 1'b0, 1'b0, f_wait);
        step("to_trap", 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01));
        step("to_hold", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01));
        check("to_instret", 32'(bus.instret), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
